exec_ctrl: RTL and testbench
============================

# exec_ctrl

Execute-stage controller for the multi-cycle RISC-V core: accepts one decoded instruction over a valid/ready handshake and drives the ALU's `ctrl`/`in_1`/`in_2` inputs from registers. It captures the ALU's `out` and `zero` and returns result, branch outcome and illegal flag over a second valid/ready handshake. It is the only driver of the ALU inputs and the only consumer of its outputs.

## Interface
- `WAIT_CYCLES`, default 0: extra EXEC cycles before ALU result is captured (0..15).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on edge where valid&ready.
- `req_opcode` in 7: instruction bits [6:0].
- `req_funct3` in 3: instruction bits [14:12].
- `req_funct7_5` in 1: instruction bit 30.
- `req_rs1`, `req_rs2`, `req_imm` in data_port (32 bits): operand values, sign-extended immediate.
- `alu_ctrl` out 2: ALU operation (AND/OR/ADD/SUB).
- `alu_in_1`, `alu_in_2` out data_port: ALU operands.
- `alu_out` in data_port; `alu_zero` in 1: ALU result and zero flag.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_result` out data_port; `rsp_taken` out 1; `rsp_illegal` out 1.

## Operation
- Decode (latched at accept):
  - 0110011 R: f3 000 → ADD (f7_5=0) / SUB (f7_5=1); 111 → AND; 110 → OR; other f3 illegal. in_2=rs2.
  - 0010011 I: 000 ADD, 111 AND, 110 OR, in_2=imm; other f3 illegal.
  - 0000011 load, 0100011 store: ADD, in_2=imm.
  - 1100011 branch: SUB, in_2=rs2; f3 000 BEQ taken=zero, 001 BNE taken=!zero; other f3 illegal.
  - Any other opcode: illegal.
- FSM:
  - IDLE: req_ready=1. Accept → latch operands/ctrl. Go to EXEC if legal; go to RESP with result=0, taken=0, illegal=1 if illegal. In the illegal case the ALU registers are not updated.
  - EXEC: counter increments from 0. When counter==WAIT_CYCLES, capture alu_out→rsp_result and taken → RESP. Non-branch: taken=0.
  - RESP: rsp_valid=1. On rsp_ready → IDLE. Response fields stay stable while waiting.
- req_ready=0 outside IDLE; requests presented while busy are ignored.
- ALU outputs come only from registers; they hold their last value in IDLE and RESP.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_taken 0, rsp_illegal 0, alu_ctrl ADD, alu_in_1/2 0, counter 0.
- Accept at edge N → ALU inputs valid from cycle N+1. Capture at edge N+1+WAIT_CYCLES. rsp_valid high from N+2+WAIT_CYCLES. Illegal request: rsp_valid high from N+1.
- Throughput: one instruction per 3+WAIT_CYCLES cycles, given rsp_ready high.
- Reset mid-EXEC or mid-RESP: the operation is abandoned with no response; all registers take their reset values on the next edge.
- ALU treated as purely combinational within the EXEC cycle(s).

## Configuration
- `EXEC_CTRL_BACK_TO_BACK_EN` defined: in RESP, req_ready=rsp_ready. A request accepted on the same edge the response is consumed goes directly to EXEC (or RESP if illegal). Throughput becomes one per 2+WAIT_CYCLES cycles.
- Undefined: req_ready only in IDLE, as above.

## Structure
- Def package: data_port; ALU ctrl constants AND/OR/ADD/SUB; opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH; exec state enum (IDLE, EXEC, RESP).
- Sub-module `exec_decode` (combinational): opcode/funct3/funct7_5 → ctrl, use_imm, is_branch, branch_inv, illegal.
- ALU instantiated by the parent alongside exec_ctrl, not inside it.

## Test plan
- WAIT=0, R-type ADD, rs1=5, rs2=7, accept edge N → alu_ctrl=ADD, rsp_valid at N+2, result 12, taken 0, illegal 0.
- R-type SUB (f7_5=1), rs1=3, rs2=5 → result 0xFFFF_FFFE; ORI rs1=0xF0, imm=0x0F → result 0xFF.
- BEQ rs1=rs2=0x10 → result 0, taken 1; BNE same operands → taken 0; BEQ 1 vs 2 → taken 0.
- LUI (0110111), accept at N → rsp_valid at N+1, illegal 1, result 0; alu_in_1/2 unchanged from previous op.
- WAIT_CYCLES=3, rsp_ready low 4 cycles → rsp_valid from N+5, result stable, req_ready low throughout; IDLE one edge after rsp_ready rises.
- Reset during EXEC → next cycle rsp_valid 0, req_ready 1; with `EXEC_CTRL_BACK_TO_BACK_EN`, continuous ADDs with rsp_ready=1 complete every 2 cycles (WAIT=0).

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: operand type, ALU
// control codes, opcode constants and the FSM state encoding.
package exec_ctrl_pkg;

  typedef logic [31:0] data_port;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_ctrl_if.sv
// Request/response bundle between the issue logic (master) and exec_ctrl (slave).
interface exec_ctrl_if;
  import exec_ctrl_pkg::*;

  // Both channels: a transfer happens on the rising edge where valid and ready
  // are both high; the sender holds valid and payload stable until that edge.
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_opcode;
  logic [2:0] req_funct3;
  logic       req_funct7_5;
  data_port   req_rs1;
  data_port   req_rs2;
  data_port   req_imm;

  logic       rsp_valid;
  logic       rsp_ready;
  data_port   rsp_result;
  logic       rsp_taken;
  logic       rsp_illegal;

  modport master (
    output req_valid, req_opcode, req_funct3, req_funct7_5, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_taken, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_funct7_5, req_rs1, req_rs2, req_imm,
    output req_ready,
    output rsp_valid, rsp_result, rsp_taken, rsp_illegal,
    input  rsp_ready
  );

endinterface

// File: rtl/exec_decode.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control, operand
// select, branch condition and illegal flag.
module exec_decode
  import exec_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [1:0] ctrl_o,
  output logic       use_imm_o,
  output logic       is_branch_o,
  output logic       branch_inv_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o       = ALU_ADD;
    use_imm_o    = 1'b0;
    is_branch_o  = 1'b0;
    branch_inv_o = 1'b0;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_R: begin
        case (funct3_i)
          3'b000:  ctrl_o = funct7_5_i ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl_o = ALU_AND;
          3'b110:  ctrl_o = ALU_OR;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_IMM: begin
        use_imm_o = 1'b1;
        case (funct3_i)
          3'b000:  ctrl_o = ALU_ADD;
          3'b111:  ctrl_o = ALU_AND;
          3'b110:  ctrl_o = ALU_OR;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        use_imm_o = 1'b1;
      end
      OP_BRANCH: begin
        // Branches compare by subtraction; the zero flag carries the outcome.
        ctrl_o      = ALU_SUB;
        is_branch_o = 1'b1;
        case (funct3_i)
          3'b000:  branch_inv_o = 1'b0;
          3'b001:  branch_inv_o = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: registers ALU inputs, captures the ALU result and
// returns it over a response handshake. Option: EXEC_CTRL_BACK_TO_BACK_EN.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  exec_ctrl_if.slave  bus,
  output logic [1:0]  alu_ctrl,
  output data_port    alu_in_1,
  output data_port    alu_in_2,
  input  data_port    alu_out,
  input  logic        alu_zero,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_EXEC    = 2'(ST_EXEC);
  localparam logic [1:0] S_RESP    = 2'(ST_RESP);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ctrl_q, ctrl_d;
  data_port   in1_q, in1_d;
  data_port   in2_q, in2_d;
  logic       br_q, br_d;
  logic       inv_q, inv_d;
  data_port   result_q, result_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;

  logic [1:0] dec_ctrl;
  logic       dec_use_imm;
  logic       dec_is_branch;
  logic       dec_branch_inv;
  logic       dec_illegal;
  logic       req_ready;
  logic       accept;

  exec_decode u_decode (
    .opcode_i     (bus.req_opcode),
    .funct3_i     (bus.req_funct3),
    .funct7_5_i   (bus.req_funct7_5),
    .ctrl_o       (dec_ctrl),
    .use_imm_o    (dec_use_imm),
    .is_branch_o  (dec_is_branch),
    .branch_inv_o (dec_branch_inv),
    .illegal_o    (dec_illegal)
  );

  always_comb begin
    req_ready = 1'b0;
    if (state_q == S_IDLE) begin
      req_ready = 1'b1;
    end
`ifdef EXEC_CTRL_BACK_TO_BACK_EN
    // A new request may enter on the same edge the pending response leaves.
    else if (state_q == S_RESP) begin
      req_ready = bus.rsp_ready;
    end
`endif
  end

  assign accept = bus.req_valid & req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    br_d      = br_q;
    inv_d     = inv_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        if (cnt_q == WAIT_LAST) begin
          state_d   = S_RESP;
          cnt_d     = 4'd0;
          result_d  = alu_out;
          taken_d   = br_q & (alu_zero ^ inv_q);
          illegal_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Illegal requests skip EXEC and leave the ALU operands untouched.
    if (accept) begin
      if (dec_illegal) begin
        state_d   = S_RESP;
        result_d  = '0;
        taken_d   = 1'b0;
        illegal_d = 1'b1;
      end else begin
        state_d = S_EXEC;
        cnt_d   = 4'd0;
        ctrl_d  = dec_ctrl;
        in1_d   = bus.req_rs1;
        in2_d   = dec_use_imm ? bus.req_imm : bus.req_rs2;
        br_d    = dec_is_branch;
        inv_d   = dec_branch_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ctrl_q    <= ALU_ADD;
      in1_q     <= '0;
      in2_q     <= '0;
      br_q      <= 1'b0;
      inv_q     <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      br_q      <= br_d;
      inv_q     <= inv_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_result  = result_q;
  assign bus.rsp_taken   = taken_q;
  assign bus.rsp_illegal = illegal_q;
  assign alu_ctrl        = ctrl_q;
  assign alu_in_1        = in1_q;
  assign alu_in_2        = in2_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: two instances (WAIT_CYCLES 0 and 3) each with an ALU
// model; directed vectors feed a response scoreboard plus timing checks.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

`ifdef EXEC_CTRL_BACK_TO_BACK_EN
  localparam int TP_GAP = 2;
`else
  localparam int TP_GAP = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  exec_ctrl_if bus0 ();
  exec_ctrl_if bus1 ();

  logic        rv     [2];
  logic [6:0]  rop    [2];
  logic [2:0]  rf3    [2];
  logic        rf7    [2];
  data_port    rrs1   [2];
  data_port    rrs2   [2];
  data_port    rimm   [2];
  logic        rr     [2];
  logic        qready [2];
  logic        svalid [2];
  data_port    sres   [2];
  logic        stk    [2];
  logic        sil    [2];
  logic [1:0]  a_ctrl [2];
  data_port    a_in1  [2];
  data_port    a_in2  [2];
  data_port    a_out  [2];
  logic        a_zero [2];
  logic [1:0]  st     [2];
  data_port    last1  [2];
  data_port    last2  [2];
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  assign bus0.req_valid = rv[0];   assign bus1.req_valid = rv[1];
  assign bus0.req_opcode = rop[0]; assign bus1.req_opcode = rop[1];
  assign bus0.req_funct3 = rf3[0]; assign bus1.req_funct3 = rf3[1];
  assign bus0.req_funct7_5 = rf7[0]; assign bus1.req_funct7_5 = rf7[1];
  assign bus0.req_rs1 = rrs1[0];   assign bus1.req_rs1 = rrs1[1];
  assign bus0.req_rs2 = rrs2[0];   assign bus1.req_rs2 = rrs2[1];
  assign bus0.req_imm = rimm[0];   assign bus1.req_imm = rimm[1];
  assign bus0.rsp_ready = rr[0];   assign bus1.rsp_ready = rr[1];
  assign qready[0] = bus0.req_ready; assign qready[1] = bus1.req_ready;
  assign svalid[0] = bus0.rsp_valid; assign svalid[1] = bus1.rsp_valid;
  assign sres[0] = bus0.rsp_result;  assign sres[1] = bus1.rsp_result;
  assign stk[0] = bus0.rsp_taken;    assign stk[1] = bus1.rsp_taken;
  assign sil[0] = bus0.rsp_illegal;  assign sil[1] = bus1.rsp_illegal;

  function automatic data_port alu_f(input logic [1:0] c, input data_port a, input data_port b);
    case (c)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      default: return a - b;
    endcase
  endfunction

  assign a_out[0]  = alu_f(a_ctrl[0], a_in1[0], a_in2[0]);
  assign a_out[1]  = alu_f(a_ctrl[1], a_in1[1], a_in2[1]);
  assign a_zero[0] = (a_out[0] == 32'd0);
  assign a_zero[1] = (a_out[1] == 32'd0);

  exec_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .alu_ctrl(a_ctrl[0]), .alu_in_1(a_in1[0]), .alu_in_2(a_in2[0]),
    .alu_out(a_out[0]), .alu_zero(a_zero[0]), .state_o(st[0])
  );

  exec_ctrl #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .alu_ctrl(a_ctrl[1]), .alu_in_1(a_in1[1]), .alu_in_2(a_in2[1]),
    .alu_out(a_out[1]), .alu_zero(a_zero[1]), .state_o(st[1])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int d, input logic [33:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Scoreboard monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    logic [33:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!reset && svalid[d] && rr[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected%0d: actual=response required=none", d);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check($sformatf("sb_rsp%0d", d), 64'({sil[d], stk[d], sres[d]}), 64'(e));
        end
      end
    end
  end

  task automatic issue(input int d, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input data_port rs1, input data_port rs2, input data_port imm,
                       input logic [1:0] e_ctrl, input data_port e_in2, input data_port e_res,
                       input logic e_tk, input logic e_il, input int e_lat, input string nm);
    int n;
    bit got;
    push(d, {e_il, e_tk, e_res});
    @(posedge clk); #1;
    rv[d] = 1'b1; rop[d] = op; rf3[d] = f3; rf7[d] = f7;
    rrs1[d] = rs1; rrs2[d] = rs2; rimm[d] = imm;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = qready[d];
    end
    check({nm, "_accept"}, 64'(got), 64'(1));
    n = cyc + 1;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    @(negedge clk);
    if (e_il) begin
      check({nm, "_in1_kept"}, 64'(a_in1[d]), 64'(last1[d]));
      check({nm, "_in2_kept"}, 64'(a_in2[d]), 64'(last2[d]));
    end else begin
      check({nm, "_ctrl"}, 64'(a_ctrl[d]), 64'(e_ctrl));
      check({nm, "_in1"}, 64'(a_in1[d]), 64'(rs1));
      check({nm, "_in2"}, 64'(a_in2[d]), 64'(e_in2));
      last1[d] = rs1;
      last2[d] = e_in2;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (svalid[d]) got = 1'b1;
      else begin
        check({nm, "_busy_ready"}, 64'(qready[d]), 64'(0));
        @(negedge clk);
      end
    end
    check({nm, "_valid"}, 64'(got), 64'(1));
    check({nm, "_latency"}, 64'(cyc + 1 - n), 64'(e_lat));
  endtask

  initial begin
    int  acc[4];
    int  na;
    bit  seen;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rop[d] = '0; rf3[d] = '0; rf7[d] = 1'b0;
      rrs1[d] = '0; rrs2[d] = '0; rimm[d] = '0; rr[d] = 1'b1;
      last1[d] = '0; last2[d] = '0;
    end
    acc = '{default: 0};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 64'(qready[d]), 64'(1));
      check($sformatf("rst_valid%0d", d), 64'(svalid[d]), 64'(0));
      check($sformatf("rst_rsp%0d", d), 64'({sil[d], stk[d], sres[d]}), 64'(0));
      check($sformatf("rst_ctrl%0d", d), 64'(a_ctrl[d]), 64'(ALU_ADD));
      check($sformatf("rst_in%0d", d), 64'({a_in1[d], a_in2[d]}), 64'(0));
      check($sformatf("rst_state%0d", d), 64'(st[d]), 64'(ST_IDLE));
    end

    // WAIT_CYCLES=0 directed vectors
    issue(0, OP_R, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, ALU_ADD, 32'd7, 32'd12, 1'b0, 1'b0, 2, "add");
    issue(0, OP_R, 3'b000, 1'b1, 32'd3, 32'd5, 32'd0, ALU_SUB, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, "sub");
    issue(0, OP_IMM, 3'b110, 1'b0, 32'hF0, 32'h123, 32'h0F, ALU_OR, 32'h0F, 32'hFF, 1'b0, 1'b0, 2, "ori");
    issue(0, OP_IMM, 3'b111, 1'b0, 32'hFF00_FF00, 32'h5, 32'h0FF0, ALU_AND, 32'h0FF0, 32'h0000_0F00, 1'b0, 1'b0, 2, "andi");
    issue(0, OP_IMM, 3'b000, 1'b1, 32'd40, 32'd9, 32'hFFFF_FFFE, ALU_ADD, 32'hFFFF_FFFE, 32'd38, 1'b0, 1'b0, 2, "addi");
    issue(0, OP_R, 3'b111, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, ALU_AND, 32'hFF00, 32'hF000, 1'b0, 1'b0, 2, "and");
    issue(0, OP_R, 3'b110, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, ALU_OR, 32'hFF00, 32'hFFF0, 1'b0, 1'b0, 2, "or");
    issue(0, OP_LOAD, 3'b010, 1'b0, 32'h1000, 32'h77, 32'hFFFF_FFFC, ALU_ADD, 32'hFFFF_FFFC, 32'hFFC, 1'b0, 1'b0, 2, "load");
    issue(0, OP_STORE, 3'b010, 1'b0, 32'h2000, 32'h77, 32'd8, ALU_ADD, 32'd8, 32'h2008, 1'b0, 1'b0, 2, "store");
    issue(0, OP_BRANCH, 3'b000, 1'b0, 32'h10, 32'h10, 32'h40, ALU_SUB, 32'h10, 32'd0, 1'b1, 1'b0, 2, "beq_eq");
    issue(0, OP_BRANCH, 3'b001, 1'b0, 32'h10, 32'h10, 32'h40, ALU_SUB, 32'h10, 32'd0, 1'b0, 1'b0, 2, "bne_eq");
    issue(0, OP_BRANCH, 3'b001, 1'b0, 32'd1, 32'd2, 32'h40, ALU_SUB, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, "bne_ne");
    issue(0, OP_BRANCH, 3'b000, 1'b0, 32'd1, 32'd2, 32'h40, ALU_SUB, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 2, "beq_ne");
    issue(0, 7'b0110111, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1, "lui");
    issue(0, OP_R, 3'b001, 1'b0, 32'd9, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1, "r_f3_bad");
    issue(0, OP_IMM, 3'b010, 1'b0, 32'd9, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1, "i_f3_bad");
    issue(0, OP_BRANCH, 3'b100, 1'b0, 32'd9, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1, "br_f3_bad");

    // WAIT_CYCLES=3 with the response held off for four cycles
    rr[1] = 1'b0;
    issue(1, OP_R, 3'b000, 1'b0, 32'h100, 32'h23, 32'd0, ALU_ADD, 32'h23, 32'h123, 1'b0, 1'b0, 5, "w3_add");
    for (int k = 0; k < 4; k++) begin
      check("hold_valid", 64'(svalid[1]), 64'(1));
      check("hold_result", 64'(sres[1]), 64'(32'h123));
      check("hold_ready", 64'(qready[1]), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    rr[1] = 1'b1;
    @(negedge clk);
    check("hold_state_resp", 64'(st[1]), 64'(ST_RESP));
    @(negedge clk);
    check("hold_state_idle", 64'(st[1]), 64'(ST_IDLE));
    check("hold_idle_ready", 64'(qready[1]), 64'(1));
    check("hold_idle_valid", 64'(svalid[1]), 64'(0));

    // Reset while dut1 is in EXEC: no response may follow
    @(posedge clk); #1;
    rv[1] = 1'b1; rop[1] = OP_R; rf3[1] = 3'b000; rf7[1] = 1'b0;
    rrs1[1] = 32'd9; rrs2[1] = 32'd9;
    @(negedge clk);
    check("rx_accept_ready", 64'(qready[1]), 64'(1));
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(negedge clk);
    check("rx_in_exec", 64'(st[1]), 64'(ST_EXEC));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rx_valid", 64'(svalid[1]), 64'(0));
    check("rx_ready", 64'(qready[1]), 64'(1));
    check("rx_state", 64'(st[1]), 64'(ST_IDLE));
    check("rx_ctrl", 64'(a_ctrl[1]), 64'(ALU_ADD));
    check("rx_in", 64'({a_in1[1], a_in2[1]}), 64'(0));
    check("rx_rsp", 64'({sil[1], stk[1], sres[1]}), 64'(0));
    for (int d = 0; d < 2; d++) begin
      last1[d] = '0;
      last2[d] = '0;
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | svalid[1];
    end
    check("rx_no_response", 64'(seen), 64'(0));

    // Continuous ADD stream on dut0 with rsp_ready held high
    rr[0] = 1'b1;
    @(posedge clk); #1;
    na = 0;
    rv[0] = 1'b1; rop[0] = OP_R; rf3[0] = 3'b000; rf7[0] = 1'b0;
    rrs1[0] = 32'd100; rrs2[0] = 32'd1;
    push(0, {2'b00, 32'd101});
    for (int k = 0; k < 40 && na < 4; k++) begin
      @(negedge clk);
      if (qready[0]) begin
        acc[na] = cyc + 1;
        na++;
        @(posedge clk); #1;
        if (na < 4) begin
          rrs2[0] = 32'(na + 1);
          push(0, {2'b00, 32'd100 + 32'(na + 1)});
        end else begin
          rv[0] = 1'b0;
        end
      end
    end
    check("tp_count", 64'(na), 64'(4));
    for (int k = 1; k < 4; k++) begin
      check($sformatf("tp_gap%0d", k), 64'(acc[k] - acc[k-1]), 64'(TP_GAP));
    end

    for (int k = 0; k < 20 && (exp_q0.size() + exp_q1.size()) != 0; k++) begin
      @(negedge clk);
    end
    check("sb_drain", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
